// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory responder.
//   DATA_WIDTH / ADDR_WIDTH : MEM-stage word and address widths
//   BYTES_PER_WORD          : byte beats per word transfer
//   ZeroWord                : reset value for word registers
//   dmem_state_e            : responder FSM encoding
package dmem_port_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [DATA_WIDTH-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_READ,
    DMEM_WRITE,
    DMEM_DONE
  } dmem_state_e;
endpackage

// File: rtl/dmem_port.sv
// Data-memory responder: serves word-aligned MEM-stage requests from a
// byte-wide synchronous RAM (1-cycle read latency), one byte beat per cycle.
// Ports:
//   CLK, RST_N          : clock, async active-low reset
//   mem_addr/read/write : request (addr[1:0] and bits above ADDR_W-1 ignored)
//   mem_mask, mem_wdata : byte enables and lane-aligned write data
//   mem_data            : read word, valid in DONE, held otherwise
//   mem_stall           : pipeline hold while a request is in flight
//   ram_addr/we/wdata   : byte RAM request side
//   ram_rdata           : byte RAM read data, one cycle after its address
module dmem_port
  import dmem_port_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            mem_mask,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_stall,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  dmem_state_e             state_q, state_d;
  logic [2:0]              beat_q, beat_d;
  logic                    cap;
  logic [ADDR_W-3:0]       base_q;
  logic [3:0]              mask_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdbuf_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [1:0]              rd_lane;

  // Word offset and out-of-range address bits are ignored by design.
  logic unused_addr;
  assign unused_addr = ^{mem_addr[ADDR_WIDTH-1:ADDR_W], mem_addr[1:0]};

  // RAM data arriving in beat N belongs to the address issued in beat N-1.
  assign rd_lane = beat_q[1:0] - 2'd1;

  assign mem_data  = mem_data_q;
  assign mem_stall = RST_N && ((state_q == DMEM_IDLE && (mem_read || mem_write)) ||
                               state_q == DMEM_READ || state_q == DMEM_WRITE);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cap       = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      DMEM_IDLE: begin
        beat_d = '0;
        // Write takes priority when both strobes are asserted.
        if (mem_write) begin
          cap     = 1'b1;
          state_d = DMEM_WRITE;
        end else if (mem_read) begin
          cap     = 1'b1;
          state_d = DMEM_READ;
        end
      end
      DMEM_READ: begin
        // Beat 4 issues nothing; it only collects the last byte.
        if (beat_q < 3'd4) ram_addr = {base_q, beat_q[1:0]};
        if (beat_q == 3'd4) state_d = DMEM_DONE;
        else                beat_d  = beat_q + 3'd1;
      end
      DMEM_WRITE: begin
        // All four beats run; masked-off lanes simply don't strobe.
        ram_addr  = {base_q, beat_q[1:0]};
        ram_wdata = wdata_q[{beat_q[1:0], 3'b000} +: 8];
        ram_we    = mask_q[beat_q[1:0]];
        if (beat_q == 3'd3) state_d = DMEM_DONE;
        else                beat_d  = beat_q + 3'd1;
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= DMEM_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= ZeroWord;
      rdbuf_q    <= ZeroWord;
      mem_data_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (cap) begin
        base_q  <= mem_addr[ADDR_W-1:2];
        mask_q  <= mem_mask;
        wdata_q <= mem_wdata;
      end
      if (state_q == DMEM_READ && beat_q != 3'd0) begin
        rdbuf_q[{rd_lane, 3'b000} +: 8] <= ram_rdata;
        // Last byte lands on the same edge, so bypass it into the result.
        if (beat_q == 3'd4) mem_data_q <= {ram_rdata, rdbuf_q[23:0]};
      end
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: behavioural byte RAM, shadow memory model,
// and queues of expected RAM writes and read words.
module tb_dmem_port;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_mask = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_data;
  logic        mem_stall;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  ram [0:131071];
  logic [7:0]  mdl [0:131071];
  logic [31:0] wq[$];
  logic [31:0] rdq[$];
  logic [31:0] last_rd = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  dmem_port #(.ADDR_W(17)) dut (
    .CLK(CLK), .RST_N(RST_N), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_data(mem_data), .mem_stall(mem_stall), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Every RAM write strobe must match the next expected {addr, byte}.
  always @(negedge CLK) begin
    if (RST_N && ram_we) begin
      if (wq.size() == 0) chk("wr_extra", {7'b0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
      else chk("wr_beat", {7'b0, ram_addr, ram_wdata}, wq.pop_front());
    end
  end

  function automatic logic [31:0] mdl_word(input logic [16:0] b);
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] wdata, input int exp_cyc);
    int cyc;
    logic [16:0] b;
    b = {addr[16:2], 2'b00};
    if (wr) begin
      for (int i = 0; i < 4; i++) if (mask[i]) begin
        wq.push_back({7'b0, b + 17'(i), wdata[8*i +: 8]});
        mdl[b + 17'(i)] = wdata[8*i +: 8];
      end
    end else if (rd) rdq.push_back(mdl_word(b));
    @(posedge CLK); #1;
    mem_addr = addr; mem_read = rd; mem_write = wr; mem_mask = mask; mem_wdata = wdata;
    cyc = 0;
    @(negedge CLK);
    while (mem_stall && cyc < 20) begin
      if (cyc >= 1 && cyc <= 4) chk("beat_addr", {15'b0, ram_addr}, {15'b0, b + 17'(cyc - 1)});
      cyc++;
      @(negedge CLK);
    end
    chk("stall_cycles", cyc, exp_cyc);
    if (rd && !wr) begin
      last_rd = rdq.pop_front();
      chk("rd_data", mem_data, last_rd);
    end else chk("data_hold", mem_data, last_rd);
    chk("done_we", {31'b0, ram_we}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge CLK); #1;
    chk("idle_stall", {31'b0, mem_stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 131072; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end
    for (int i = 0; i < 4; i++) begin
      ram[17'h100 + i] = 8'(8'h11 * (i + 1)); mdl[17'h100 + i] = 8'(8'h11 * (i + 1));
      ram[17'h200 + i] = 8'(i + 1);           mdl[17'h200 + i] = 8'(i + 1);
    end

    // Reset holds everything quiet even with a request present.
    mem_read = 1'b1;
    #13;
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_we", {31'b0, ram_we}, 32'd0);
    chk("rst_addr", {15'b0, ram_addr}, 32'd0);
    mem_read = 1'b0;
    @(negedge CLK); RST_N = 1'b1;

    xfer(1, 0, 32'h0000_0102, 4'h0, 32'h0, 6);            // read 0x44332211
    xfer(0, 1, 32'h0000_0200, 4'b0100, 32'h00AB_0000, 5); // single-lane write
    xfer(1, 0, 32'h0000_0200, 4'h0, 32'h0, 6);            // 0x04AB0201
    xfer(0, 1, 32'h0001_FFFC, 4'hF, 32'hDEAD_BEEF, 5);
    xfer(1, 0, 32'h0001_FFFC, 4'h0, 32'h0, 6);
    xfer(1, 0, 32'h0003_FFFC, 4'h0, 32'h0, 6);            // aliases to 0x1FFFC
    xfer(1, 1, 32'h0000_0400, 4'hF, 32'h5566_7788, 5);    // write wins
    xfer(1, 0, 32'h0000_0400, 4'h0, 32'h0, 6);
    xfer(0, 1, 32'h0000_0100, 4'h0, 32'hFFFF_FFFF, 5);    // no-mask write
    xfer(1, 0, 32'h0000_0100, 4'h0, 32'h0, 6);            // unchanged
    chk("exp_word", last_rd, 32'h4433_2211);

    // Reset during write beat 2: lanes 0-1 land, lanes 2-3 never do.
    wq.push_back({7'b0, 17'h300, 8'hD4});
    wq.push_back({7'b0, 17'h301, 8'hC3});
    mdl[17'h300] = 8'hD4; mdl[17'h301] = 8'hC3;
    @(posedge CLK); #1;
    mem_addr = 32'h300; mem_write = 1'b1; mem_mask = 4'hF; mem_wdata = 32'hA1B2_C3D4;
    @(posedge CLK); @(posedge CLK); @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, ram_we}, 32'd0);
    chk("mid_rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("mid_rst_addr", {15'b0, ram_addr}, 32'd0);
    mem_write = 1'b0;
    @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
    chk("part_word", {ram[17'h303], ram[17'h302], ram[17'h301], ram[17'h300]}, 32'h0000_C3D4);
    last_rd = 32'h0;
    xfer(1, 0, 32'h0000_0300, 4'h0, 32'h0, 6);

    chk("wq_empty", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
